// File: rtl/masked_dom_gate_seq_pkg.sv
// masked_pkg: shared types and index helpers for the sequential masked DOM gate.
package masked_pkg;
  typedef enum logic [1:0] {IDLE, CROSS, COMP, DONE} state_t;
  function automatic int nr(input int nshares);
    return nshares * (nshares - 1) / 2;
  endfunction
  // Lexicographic index of the unordered share pair (i,j); the diagonal maps to 0 and is masked off by callers.
  function automatic int pair_idx(input int i, input int j, input int nshares);
    int lo;
    int hi;
    lo = i < j ? i : j;
    hi = i < j ? j : i;
    return (i == j) ? 0 : lo * nshares - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction
endpackage

// File: rtl/masked_dom_gate_seq_if.sv
// masked_dom_gate_seq_if: input, randomness and output handshakes of the masked gate.
interface masked_dom_gate_seq_if
  import masked_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int NIN = 10
);
  logic in_valid;
  logic in_ready;
  logic op_or;
  logic [NIN*NSHARES-1:0] in_sh;
  logic [nr(NSHARES)-1:0] rnd;
  logic rnd_valid;
  logic rnd_ready;
  logic out_valid;
  logic out_ready;
  logic [NSHARES-1:0] x_sh;
  logic [NSHARES-1:0] xbar_sh;
  modport master (
    output in_valid, op_or, in_sh, rnd, rnd_valid, out_ready,
    input in_ready, rnd_ready, out_valid, x_sh, xbar_sh
  );
  modport slave (
    input in_valid, op_or, in_sh, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_valid, x_sh, xbar_sh
  );
endinterface

// File: rtl/masked_dom_gate_seq_dom_and_stage.sv
// dom_and_stage: DOM-AND accumulator with a registered cross/inner-domain layer and share compression.
module dom_and_stage
  import masked_pkg::*;
#(
  parameter int NSHARES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NSHARES-1:0]       load_val,
  input  logic                     cross_en,
  input  logic [NSHARES-1:0]       b,
  input  logic [nr(NSHARES)-1:0]   rnd,
  input  logic                     comp_en,
  input  logic                     clr,
  output logic [NSHARES-1:0]       y
);
  logic [NSHARES-1:0] acc_d, acc_q;
  // Row i holds every partial product landing in share domain i; the diagonal is the unmasked inner term.
  logic [NSHARES-1:0][NSHARES-1:0] c_d, c_q;
  always_comb begin
    c_d = c_q;
    acc_d = acc_q;
    for (int i = 0; i < NSHARES; i++) begin
      y[i] = ^c_q[i];
      for (int j = 0; j < NSHARES; j++)
        if (cross_en) c_d[i][j] = (acc_q[i] & b[j]) ^ ((i != j) & rnd[pair_idx(i, j, NSHARES)]);
      if (comp_en) acc_d[i] = y[i];
    end
    if (load) acc_d = load_val;
    if (clr) begin
      acc_d = '0;
      c_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      c_q <= '0;
    end else begin
      acc_q <= acc_d;
      c_q <= c_d;
    end
endmodule

// File: rtl/masked_dom_gate_seq.sv
// masked_dom_gate_seq: sequential masked AND/OR over NIN shared bits, one DOM-AND step per two cycles.
module masked_dom_gate_seq
  import masked_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int NIN = 10
) (
  input logic clk,
  input logic rst_n,
  masked_dom_gate_seq_if.slave bus
);
  localparam int IW = $clog2(NIN);
  localparam logic [NSHARES-1:0] S0 = NSHARES'(1);
  localparam logic [IW-1:0] LAST = IW'(NIN - 1);
  state_t state_d, state_q;
  logic [IW-1:0] idx_d, idx_q;
  logic [NIN*NSHARES-1:0] sh_d, sh_q;
  logic op_d, op_q;
  logic [NSHARES-1:0] x_d, x_q, xb_d, xb_q;
  logic ov_d, ov_q;
  logic load, cross_en, comp_en, clr;
  logic [NSHARES-1:0] inv, load_val, b, y;
  // OR is evaluated as ~AND(~v): flipping share 0 negates the shared value.
  assign inv = op_q ? S0 : '0;
  assign load_val = bus.in_sh[NSHARES-1:0] ^ (bus.op_or ? S0 : '0);
  assign b = sh_q[int'(idx_q)*NSHARES +: NSHARES] ^ inv;
  dom_and_stage #(.NSHARES(NSHARES)) u_stage (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .cross_en(cross_en),
    .b(b), .rnd(bus.rnd), .comp_en(comp_en), .clr(clr), .y(y)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    op_d = op_q;
    x_d = x_q;
    xb_d = xb_q;
    ov_d = ov_q;
    load = 1'b0;
    cross_en = 1'b0;
    comp_en = 1'b0;
    clr = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sh_d = bus.in_sh;
        op_d = bus.op_or;
        load = 1'b1;
        idx_d = IW'(1);
        state_d = CROSS;
      end
      CROSS: if (bus.rnd_valid) begin
        cross_en = 1'b1;
        state_d = COMP;
      end
      COMP: begin
        comp_en = 1'b1;
        if (idx_q == LAST) begin
          // Final compression goes straight to the output regs while all working state is wiped.
          x_d = y ^ inv;
          xb_d = y ^ inv ^ S0;
          ov_d = 1'b1;
          clr = 1'b1;
          sh_d = '0;
          idx_d = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          state_d = CROSS;
        end
      end
      DONE: if (bus.out_ready) begin
        x_d = '0;
        xb_d = '0;
        ov_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
      op_q <= 1'b0;
      x_q <= '0;
      xb_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      op_q <= op_d;
      x_q <= x_d;
      xb_q <= xb_d;
      ov_q <= ov_d;
    end
  assign bus.in_ready = state_q == IDLE;
  assign bus.rnd_ready = state_q == CROSS;
  assign bus.out_valid = ov_q;
  assign bus.x_sh = x_q;
  assign bus.xbar_sh = xb_q;
endmodule

// File: tb/tb_masked_dom_gate_seq.sv
// tb_masked_dom_gate_seq: scoreboard bench for the masked gate in 2-share/10-input and 3-share/4-input builds.
module tb_masked_dom_gate_seq;
  import masked_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ncmp = 0;
  int nerr = 0;
  int rnd_hs_a = 0;
  typedef struct {logic x; int due;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  masked_dom_gate_seq_if #(.NSHARES(2), .NIN(10)) ia ();
  masked_dom_gate_seq_if #(.NSHARES(3), .NIN(4)) ib ();
  masked_dom_gate_seq #(.NSHARES(2), .NIN(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  masked_dom_gate_seq #(.NSHARES(3), .NIN(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    ncmp++;
    nerr++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [19:0] mk_a(input logic [9:0] v);
    logic [19:0] s;
    for (int k = 0; k < 10; k++) begin
      s[2*k+1] = 1'($urandom);
      s[2*k] = v[k] ^ s[2*k+1];
    end
    return s;
  endfunction

  function automatic logic [11:0] mk_b(input logic [3:0] v);
    logic [11:0] s;
    for (int k = 0; k < 4; k++) begin
      s[3*k+1] = 1'($urandom);
      s[3*k+2] = 1'($urandom);
      s[3*k] = v[k] ^ s[3*k+1] ^ s[3*k+2];
    end
    return s;
  endfunction

  always @(negedge clk) begin
    ia.rnd <= 1'($urandom);
    ib.rnd <= 3'($urandom);
  end

  // Monitors sample just after the falling edge: outputs are settled and inputs show what the next rising edge sees.
  logic pova = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (ia.rnd_valid && ia.rnd_ready) rnd_hs_a++;
    if (ia.out_valid && !pova) begin
      if (qa.size() == 0) fail_now("a_unexpected_out");
      else begin
        e = qa.pop_front();
        chk("a_x_parity", ^ia.x_sh, e.x);
        chk("a_xbar_parity", ^ia.xbar_sh, !e.x);
        chk("a_latency_cycle", cyc, e.due);
      end
    end
    pova <= ia.out_valid;
  end

  logic povb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (ib.out_valid && !povb) begin
      if (qb.size() == 0) fail_now("b_unexpected_out");
      else begin
        e = qb.pop_front();
        chk("b_x_parity", ^ib.x_sh, e.x);
        chk("b_xbar_parity", ^ib.xbar_sh, !e.x);
        chk("b_latency_cycle", cyc, e.due);
      end
    end
    povb <= ib.out_valid;
  end

  task automatic run_a(input logic [9:0] v, input logic op, input bit stall, input int hold);
    int e0;
    int n;
    logic [1:0] xs;
    logic [1:0] xbs;
    ia.in_sh = mk_a(v);
    ia.op_or = op;
    ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
    ia.in_sh = '0;
    e0 = cyc;
    rnd_hs_a = 0;
    qa.push_back('{x: op ? |v : &v, due: e0 + (stall ? 21 : 18)});
    if (stall) begin
      repeat (6) @(negedge clk);
      ia.rnd_valid = 1'b0;
      repeat (3) @(negedge clk);
      ia.rnd_valid = 1'b1;
    end
    n = 0;
    while (!ia.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ia.out_valid) fail_now("a_out_valid_timeout");
    chk("a_rnd_handshakes", rnd_hs_a, 9);
    if (hold > 0) begin
      xs = ia.x_sh;
      xbs = ia.xbar_sh;
      for (int c = 0; c < hold; c++) begin
        ia.in_valid = (c % 2 == 0);
        @(negedge clk);
        chk("hold_x_stable", ia.x_sh, xs);
        chk("hold_xbar_stable", ia.xbar_sh, xbs);
        chk("hold_in_ready", ia.in_ready, 0);
        chk("hold_out_valid", ia.out_valid, 1);
      end
      ia.in_valid = 1'b0;
      ia.out_ready = 1'b1;
      @(negedge clk);
      chk("accept_x_zero", ia.x_sh, 0);
      chk("accept_xbar_zero", ia.xbar_sh, 0);
      chk("accept_out_valid", ia.out_valid, 0);
      chk("accept_in_ready", ia.in_ready, 1);
    end
    n = 0;
    while (!ia.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ia.in_ready) fail_now("a_in_ready_timeout");
  endtask

  task automatic run_b(input logic [3:0] v, input logic op);
    int n;
    ib.in_sh = mk_b(v);
    ib.op_or = op;
    ib.in_valid = 1'b1;
    @(negedge clk);
    ib.in_valid = 1'b0;
    qb.push_back('{x: op ? |v : &v, due: cyc + 6});
    n = 0;
    while (!ib.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ib.out_valid) fail_now("b_out_valid_timeout");
    n = 0;
    while (!ib.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ib.in_ready) fail_now("b_in_ready_timeout");
  endtask

  initial begin
    ia.in_valid = 1'b0;
    ia.op_or = 1'b0;
    ia.in_sh = '0;
    ia.rnd_valid = 1'b1;
    ia.out_ready = 1'b1;
    ib.in_valid = 1'b0;
    ib.op_or = 1'b0;
    ib.in_sh = '0;
    ib.rnd_valid = 1'b1;
    ib.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_out_valid", ia.out_valid, 0);
    chk("rst_a_x", ia.x_sh, 0);
    chk("rst_a_xbar", ia.xbar_sh, 0);
    chk("rst_a_in_ready", ia.in_ready, 1);
    chk("rst_a_rnd_ready", ia.rnd_ready, 0);
    chk("rst_b_out_valid", ib.out_valid, 0);
    chk("rst_b_in_ready", ib.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(10'h3ff, 1'b0, 1'b0, 0);
    run_a(10'h37f, 1'b0, 1'b0, 0);
    run_a(10'h000, 1'b1, 1'b0, 0);
    run_a(10'h008, 1'b1, 1'b0, 0);
    run_a(10'h3ff, 1'b0, 1'b1, 0);
    run_a(10'h2a5, 1'b1, 1'b1, 0);
    // Reset dropped seven edges into a transaction must discard it completely.
    ia.in_sh = mk_a(10'h3ff);
    ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ia.out_valid, 0);
    chk("midrst_x", ia.x_sh, 0);
    chk("midrst_xbar", ia.xbar_sh, 0);
    chk("midrst_in_ready", ia.in_ready, 1);
    chk("midrst_rnd_ready", ia.rnd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(10'h3ff, 1'b0, 1'b0, 0);
    ia.out_ready = 1'b0;
    run_a(10'h3ff, 1'b1, 1'b0, 5);
    run_a(10'h1fe, 1'b0, 1'b0, 0);
    for (int t = 0; t < 1000; t++) run_b(4'($urandom), 1'($urandom));
    repeat (30) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
